// File: rtl/image_pixel_proc.sv
// Streaming 8-bit grayscale point-operation engine: brighten, darken, threshold, invert.
// Optional statistics counters are enabled by defining IMGPROC_STATS_EN.
module image_pixel_proc #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] inbyte,
    input  logic [DATA_W-1:0] value,
    input  logic [DATA_W-1:0] threshold,
    input  logic [1:0]        select,
`ifdef IMGPROC_STATS_EN
    output logic [31:0]       pix_count,
    output logic [31:0]       sat_count,
    output logic [31:0]       hit_count,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] outbyte
);

    localparam logic [DATA_W-1:0] MAX = {DATA_W{1'b1}};

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] result;
    logic              clamped;
    logic              hit;

    // Each operand only reaches the result through its own operation's branch,
    // so unused operands (even unknown ones) cannot disturb other operations.
    always_comb begin
        sum     = '0;
        diff    = '0;
        result  = '0;
        clamped = 1'b0;
        hit     = 1'b0;
        case (select)
            2'b00: begin
                sum     = {1'b0, inbyte} + {1'b0, value};
                clamped = sum[DATA_W];
                result  = clamped ? MAX : sum[DATA_W-1:0];
            end
            2'b01: begin
                diff    = {1'b0, inbyte} - {1'b0, value};
                clamped = diff[DATA_W];
                result  = clamped ? '0 : diff[DATA_W-1:0];
            end
            2'b10: begin
                hit    = (inbyte > threshold);
                result = hit ? MAX : '0;
            end
            default: begin
                result = ~inbyte;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outbyte   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                outbyte <= result;
            end
        end
    end

`ifdef IMGPROC_STATS_EN
    // Counters advance on the same edge that registers the result they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_count <= '0;
            sat_count <= '0;
            hit_count <= '0;
        end else if (in_valid) begin
            pix_count <= pix_count + 32'd1;
            if (clamped) begin
                sat_count <= sat_count + 32'd1;
            end
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_image_pixel_proc.sv
// Self-checking bench for image_pixel_proc: table vectors, corner sequences and a scoreboard.
// Statistics counters are checked when IMGPROC_STATS_EN is defined.
module tb_image_pixel_proc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] inbyte;
    logic [7:0] value;
    logic [7:0] threshold;
    logic [1:0] select;
    logic       out_valid;
    logic [7:0] outbyte;
`ifdef IMGPROC_STATS_EN
    logic [31:0] pix_count;
    logic [31:0] sat_count;
    logic [31:0] hit_count;
`endif

    always #5 clk = ~clk;

    image_pixel_proc #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inbyte    (inbyte),
        .value     (value),
        .threshold (threshold),
        .select    (select),
`ifdef IMGPROC_STATS_EN
        .pix_count (pix_count),
        .sat_count (sat_count),
        .hit_count (hit_count),
`endif
        .out_valid (out_valid),
        .outbyte   (outbyte)
    );

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic [7:0] pix;
        logic [7:0] val;
        logic [7:0] thr;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic       v;
        logic [7:0] d;
    } exp_t;

    exp_t       sbq[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] held = 8'h00;
    vec_t       vecs[14];

    // Reference model worked in plain integers so clamping is explicit.
    function automatic logic [7:0] model(input logic [1:0] sel, input logic [7:0] a,
                                         input logic [7:0] v, input logic [7:0] t);
        int r;
        case (sel)
            2'b00: begin r = int'(a) + int'(v); if (r > 255) r = 255; end
            2'b01: begin r = int'(a) - int'(v); if (r < 0) r = 0; end
            2'b10: r = (int'(a) > int'(t)) ? 255 : 0;
            default: r = 255 - int'(a);
        endcase
        return r[7:0];
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] s,
                                 input logic [7:0] a, input logic [7:0] val,
                                 input logic [7:0] thr, input logic [7:0] expd,
                                 input string name);
        exp_t e;
        rst = r; in_valid = v; select = s; inbyte = a; value = val; threshold = thr;
        e.name = name;
        if (r) begin
            held = 8'h00; e.v = 1'b0; e.d = 8'h00;
        end else if (v) begin
            held = expd; e.v = 1'b1; e.d = expd;
        end else begin
            e.v = 1'b0; e.d = held;
        end
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, want an entry");
            return;
        end
        e = sbq.pop_front();
        if (out_valid !== e.v) begin
            errors++;
            $display("[TB] FAIL %s out_valid: got %0b want %0b", e.name, out_valid, e.v);
        end
        checks++;
        if (outbyte !== e.d) begin
            errors++;
            $display("[TB] FAIL %s outbyte: got %02h want %02h", e.name, outbyte, e.d);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [7:0] a, input logic [7:0] val,
                        input logic [7:0] thr, input logic [7:0] expd,
                        input string name);
        applyStimulus(r, v, s, a, val, thr, expd, name);
        @(negedge clk);
        checkOutput();
    endtask

`ifdef IMGPROC_STATS_EN
    task automatic checkCount(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask
`endif

    initial begin
        logic [1:0] s;
        logic [7:0] a, v, t;
        logic       vld;

        vecs[0]  = '{"brighten 10",  2'b00, 8'h10, 8'h3C, 8'h00, 8'h4C};
        vecs[1]  = '{"brighten C3",  2'b00, 8'hC3, 8'h3C, 8'h00, 8'hFF};
        vecs[2]  = '{"brighten F0",  2'b00, 8'hF0, 8'h3C, 8'h00, 8'hFF};
        vecs[3]  = '{"darken 80",    2'b01, 8'h80, 8'h3C, 8'h00, 8'h44};
        vecs[4]  = '{"darken 3C",    2'b01, 8'h3C, 8'h3C, 8'h00, 8'h00};
        vecs[5]  = '{"darken 05",    2'b01, 8'h05, 8'h3C, 8'h00, 8'h00};
        vecs[6]  = '{"thresh A1",    2'b10, 8'hA1, 8'h00, 8'hA0, 8'hFF};
        vecs[7]  = '{"thresh A0",    2'b10, 8'hA0, 8'h00, 8'hA0, 8'h00};
        vecs[8]  = '{"thresh 00",    2'b10, 8'h00, 8'h00, 8'hA0, 8'h00};
        vecs[9]  = '{"thresh FF",    2'b10, 8'hFF, 8'h00, 8'hA0, 8'hFF};
        vecs[10] = '{"invert 00",    2'b11, 8'h00, 8'h77, 8'h33, 8'hFF};
        vecs[11] = '{"invert 5A",    2'b11, 8'h5A, 8'h12, 8'hEE, 8'hA5};
        vecs[12] = '{"brighten 00+0",2'b00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[13] = '{"darken FF-1",  2'b01, 8'hFF, 8'h01, 8'h00, 8'hFE};

        rst = 1'b1; in_valid = 1'b0; inbyte = 8'h00; value = 8'h00;
        threshold = 8'h00; select = 2'b00;
        @(negedge clk);

        // Reset holds outputs low even with valid input present.
        step(1'b1, 1'b1, 2'b00, 8'h80, 8'h00, 8'h00, 8'h00, "reset cyc0");
        step(1'b1, 1'b1, 2'b00, 8'h80, 8'h00, 8'h00, 8'h00, "reset cyc1");

        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, vecs[i].sel, vecs[i].pix, vecs[i].val, vecs[i].thr,
                 vecs[i].exp, vecs[i].name);
        end

        // Idle gap: output valid drops and data holds.
        step(1'b0, 1'b0, 2'b00, 8'h33, 8'h44, 8'h55, 8'h00, "idle hold 1");
        step(1'b0, 1'b0, 2'b11, 8'h99, 8'h44, 8'h55, 8'h00, "idle hold 2");

        // Back-to-back beats cycling the select every cycle.
        for (int i = 0; i < 12; i++) begin
            s = 2'(i % 4);
            a = 8'($urandom_range(0, 255));
            v = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            step(1'b0, 1'b1, s, a, v, t, model(s, a, v, t), "b2b cycle");
        end

        // Unknown threshold must not reach a brighten result.
        step(1'b0, 1'b1, 2'b00, 8'h20, 8'h10, 8'hxx, 8'h30, "brighten x-thr");
        step(1'b0, 1'b1, 2'b11, 8'h0F, 8'hxx, 8'hxx, 8'hF0, "invert x-ops");

        // Mid-stream reset drops the in-flight beat; the next beat runs normally.
        step(1'b0, 1'b1, 2'b00, 8'h40, 8'h01, 8'h00, 8'h41, "pre-reset beat");
        step(1'b1, 1'b1, 2'b01, 8'h40, 8'h01, 8'h00, 8'h00, "mid reset");
        step(1'b0, 1'b1, 2'b01, 8'h40, 8'h01, 8'h00, 8'h3F, "post reset beat");

        for (int i = 0; i < 40; i++) begin
            vld = 1'($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            a = 8'($urandom_range(0, 255));
            v = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            step(1'b0, vld, s, a, v, t, model(s, a, v, t), "random");
        end

`ifdef IMGPROC_STATS_EN
        step(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, "stats reset");
        step(1'b0, 1'b1, 2'b00, 8'hF0, 8'h3C, 8'h00, 8'hFF, "stats brighten F0");
        step(1'b0, 1'b1, 2'b01, 8'h05, 8'h3C, 8'h00, 8'h00, "stats darken 05");
        step(1'b0, 1'b1, 2'b10, 8'hA1, 8'h00, 8'hA0, 8'hFF, "stats thresh A1");
        step(1'b0, 1'b1, 2'b00, 8'h10, 8'h3C, 8'h00, 8'h4C, "stats brighten 10");
        checkCount("pix_count", pix_count, 32'd4);
        checkCount("sat_count", sat_count, 32'd2);
        checkCount("hit_count", hit_count, 32'd1);
        step(1'b1, 1'b1, 2'b00, 8'hF0, 8'h3C, 8'h00, 8'h00, "stats clear");
        checkCount("pix_count clear", pix_count, 32'd0);
        checkCount("sat_count clear", sat_count, 32'd0);
        checkCount("hit_count clear", hit_count, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
